// File: rtl/router_sync_if.sv
// router_sync_if: signal bundle between the router FSM / input register,
// the three output FIFOs and the router_sync steering stage.
// Optional macro ROUTER_SYNC_ADDR_ERR_EN adds the addr_err flag.
interface router_sync_if;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic       addr_err;
`endif

  // Seen from router_sync
  modport slave (
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    output addr_err,
`endif
    input  detect_add, data_in, write_enb_reg,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    output write_enb, fifo_full,
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );

  // Seen from the FSM / FIFO side
  modport master (
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    input  addr_err,
`endif
    output detect_add, data_in, write_enb_reg,
    output read_enb_0, read_enb_1, read_enb_2,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    input  write_enb, fifo_full,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );
endinterface

// File: rtl/router_sync.sv
// router_sync: latches the packet destination, steers the FSM write strobe
// to one of three FIFOs, returns that FIFO's full flag, derives per-port
// valid flags and flushes any FIFO whose data sits unread for TIMEOUT cycles.
// Optional macro ROUTER_SYNC_ADDR_ERR_EN adds a registered addr_err flag
// raised when a header carries the unused destination 2'b11.
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic     clock,
  input  logic     resetn,
  router_sync_if.slave bus
);

  logic [1:0] addr_q;
  logic [2:0] vld;
  logic [2:0] rd_en;
  logic [2:0] soft_vec;

  assign vld   = {~bus.empty_2, ~bus.empty_1, ~bus.empty_0};
  assign rd_en = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

  assign bus.vld_out_0    = vld[0];
  assign bus.vld_out_1    = vld[1];
  assign bus.vld_out_2    = vld[2];
  assign bus.soft_reset_0 = soft_vec[0];
  assign bus.soft_reset_1 = soft_vec[1];
  assign bus.soft_reset_2 = soft_vec[2];

  // Destination latch; 2'b11 (no port) out of reset so nothing is written
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= 2'b11;
    end else if (bus.detect_add) begin
      addr_q <= bus.data_in;
    end
  end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic addr_err_q;
  assign bus.addr_err = addr_err_q;

  // Flag headers addressed to the nonexistent port, held until next header
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_err_q <= 1'b0;
    end else if (bus.detect_add) begin
      addr_err_q <= (bus.data_in == 2'b11);
    end
  end
`endif

  // Steer write strobe and select full flag from the registered address
  always_comb begin
    bus.write_enb = 3'b000;
    bus.fifo_full = 1'b0;
    case (addr_q)
      2'b00: begin
        bus.write_enb = {2'b00, bus.write_enb_reg};
        bus.fifo_full = bus.full_0;
      end
      2'b01: begin
        bus.write_enb = {1'b0, bus.write_enb_reg, 1'b0};
        bus.fifo_full = bus.full_1;
      end
      2'b10: begin
        bus.write_enb = {bus.write_enb_reg, 2'b00};
        bus.fifo_full = bus.full_2;
      end
      default: begin
        bus.write_enb = 3'b000;
        bus.fifo_full = 1'b0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_port
      logic [CNT_W-1:0] cnt_q;
      logic             pulse_q;

      assign soft_vec[gi] = pulse_q;

      // Stall counter: a pulse cycle holds the count at zero, any read or
      // empty FIFO clears it, and the TIMEOUT-th stalled edge fires the flush
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end else if (pulse_q) begin
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end else if (!vld[gi] || rd_en[gi]) begin
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_q   <= '0;
          pulse_q <= 1'b1;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
          pulse_q <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
